// File: rtl/swap_sched_pkg.sv
// Shared types and sizing helper for the display-mode swap scheduler.
// Consumed by swap_scheduler and btn_debouncer.
package swap_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FIRE, S_HOLD} sched_state_t;

  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Button synchronizer + debounce; press_evt is a 1-cycle pulse on an accepted 0->1 level.
// Latency 2 sync cycles + DEBOUNCE_CYCLES stable cycles; no backpressure.
module btn_debouncer
  import swap_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int CW = (cnt_w(DEBOUNCE_CYCLES) < 1) ? 1 : cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      press_evt <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Level accepted; only a rising acceptance is a press.
        stable    <= sync2;
        cnt       <= '0;
        press_evt <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/swap_scheduler.sv
// Defers debounced mode-button (or, with SWAP_AUTO_CYCLE_EN, automatic) requests to frame_start and enforces a frame hold-off.
// swap pulses the cycle after the consuming frame_start; 1-deep queue during hold-off, further requests dropped.
module swap_scheduler
  import swap_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLDOFF_FRAMES  = 2,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic frame_start,
  input  logic auto_en,
  output logic swap,
  output logic pending
);

  localparam int HW = (cnt_w(HOLDOFF_FRAMES) < 1) ? 1 : cnt_w(HOLDOFF_FRAMES);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF_FRAMES > 0) ? HOLDOFF_FRAMES - 1 : 0);

  sched_state_t  state;
  logic          queued;
  logic [HW-1:0] hold_cnt;
  logic          press_evt;
  logic          auto_evt;
  logic          evt;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .press_evt(press_evt)
  );

  assign evt = press_evt | auto_evt;

`ifdef SWAP_AUTO_CYCLE_EN
  localparam int AW = (cnt_w(AUTO_FRAMES) < 1) ? 1 : cnt_w(AUTO_FRAMES);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

  logic [AW-1:0] auto_cnt;

  // Only idle frames with auto_en held count toward the next automatic swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_cnt <= '0;
      auto_evt <= 1'b0;
    end else begin
      auto_evt <= 1'b0;
      if (press_evt || !auto_en || state != S_IDLE) begin
        auto_cnt <= '0;
      end else if (frame_start) begin
        if (auto_cnt == AUTO_LAST) begin
          auto_cnt <= '0;
          auto_evt <= 1'b1;
        end else begin
          auto_cnt <= auto_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
  assign auto_evt       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      swap     <= 1'b0;
      pending  <= 1'b0;
      queued   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      swap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (evt) begin
            state   <= S_ARMED;
            pending <= 1'b1;
          end else begin
            pending <= 1'b0;
          end
        end
        S_ARMED: begin
          if (frame_start) begin
            state   <= S_FIRE;
            swap    <= 1'b1;
            pending <= queued;
          end
        end
        S_FIRE: begin
          hold_cnt <= '0;
          if (HOLDOFF_FRAMES == 0) begin
            state   <= (queued | evt) ? S_ARMED : S_IDLE;
            queued  <= 1'b0;
            pending <= queued | evt;
          end else begin
            state   <= S_HOLD;
            queued  <= queued | evt;
            pending <= queued | evt;
          end
        end
        S_HOLD: begin
          if (evt) begin
            queued  <= 1'b1;
            pending <= 1'b1;
          end
          if (frame_start) begin
            if (hold_cnt == HOLD_LAST) begin
              // A request landing on the exit cycle re-arms directly.
              hold_cnt <= '0;
              state    <= (queued | evt) ? S_ARMED : S_IDLE;
              queued   <= 1'b0;
              pending  <= queued | evt;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_scheduler.sv
// Directed bench for swap_scheduler with DEBOUNCE_CYCLES=4, HOLDOFF_FRAMES=2, AUTO_FRAMES=3.
// Auto-cycle scenario runs when SWAP_AUTO_CYCLE_EN is defined; otherwise auto_en is shown to be ignored.
module tb_swap_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic frame_start = 1'b0;
  logic auto_en = 1'b0;
  logic swap;
  logic pending;

  int vectors = 0;
  int miscompares = 0;
  int swap_cnt = 0;

  swap_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_FRAMES (2),
    .AUTO_FRAMES    (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .frame_start(frame_start),
    .auto_en    (auto_en),
    .swap       (swap),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (swap === 1'b1) swap_cnt <= swap_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // frame_start high for one cycle; on return the edge that sampled it has passed.
  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Full press and release; the press is accepted after 6 edges, armed after 7.
  task automatic press();
    btn_raw = 1'b1;
    ticks(12);
    btn_raw = 1'b0;
    ticks(12);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    btn_raw = 1'b0;
    do_reset();
    vectors++;
    if (swap !== 1'b0 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: swap=%b pending=%b, required 0/0", swap, pending);
    end
    tick();
    vectors++;
    if (swap !== 1'b0 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_outputs: swap=%b pending=%b, required 0/0", swap, pending);
    end
    base = swap_cnt;
    for (int f = 0; f < 10; f++) begin
      pulse_frame();
      ticks(2);
    end
    vectors++;
    if (swap_cnt - base !== 0) begin
      miscompares++;
      $display("FAIL idle_no_swap: swaps=%0d, required 0", swap_cnt - base);
    end
  endtask

  task automatic test_press_swap();
    int base;
    int waited;
    base = swap_cnt;
    btn_raw = 1'b1;
    ticks(3);
    btn_raw = 1'b0;
    ticks(12);
    vectors++;
    if (pending !== 1'b0) begin
      miscompares++;
      $display("FAIL short_press_pending: pending=%b, required 0", pending);
    end
    pulse_frame();
    ticks(2);
    vectors++;
    if (swap_cnt - base !== 0) begin
      miscompares++;
      $display("FAIL short_press_swap: swaps=%0d, required 0", swap_cnt - base);
    end

    btn_raw = 1'b1;
    waited = 0;
    while (pending !== 1'b1 && waited < 7) begin
      tick();
      waited++;
    end
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL long_press_pending: pending=%b after %0d cycles, required 1", pending, waited);
    end
    ticks(12 - waited);
    btn_raw = 1'b0;
    ticks(12);
    vectors++;
    if (swap !== 1'b0) begin
      miscompares++;
      $display("FAIL armed_no_swap: swap=%b, required 0", swap);
    end
    pulse_frame();
    vectors++;
    if (swap !== 1'b1 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL swap_after_frame: swap=%b pending=%b, required 1/0", swap, pending);
    end
    tick();
    vectors++;
    if (swap !== 1'b0) begin
      miscompares++;
      $display("FAIL swap_width: swap=%b one cycle later, required 0", swap);
    end
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      ticks(2);
    end
  endtask

  task automatic test_frame_same_cycle();
    int base;
    base = swap_cnt;
    // press_evt is high in the cycle sampled by the 7th edge after btn rises.
    btn_raw = 1'b1;
    ticks(6);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    ticks(5);
    btn_raw = 1'b0;
    ticks(12);
    vectors++;
    if (swap_cnt - base !== 0 || pending !== 1'b1) begin
      miscompares++;
      $display("FAIL same_cycle_frame: swaps=%0d pending=%b, required 0/1", swap_cnt - base, pending);
    end
    pulse_frame();
    vectors++;
    if (swap !== 1'b1) begin
      miscompares++;
      $display("FAIL same_cycle_next_frame: swap=%b, required 1", swap);
    end
    tick();
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      ticks(2);
    end
    vectors++;
    if (swap_cnt - base !== 1) begin
      miscompares++;
      $display("FAIL same_cycle_total: swaps=%0d, required 1", swap_cnt - base);
    end
  endtask

  task automatic test_queue();
    int base;
    base = swap_cnt;
    press();
    pulse_frame();
    vectors++;
    if (swap !== 1'b1) begin
      miscompares++;
      $display("FAIL queue_first_swap: swap=%b, required 1", swap);
    end
    tick();
    press();
    press();
    press();
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL queue_pending: pending=%b, required 1", pending);
    end
    pulse_frame();
    ticks(2);
    pulse_frame();
    vectors++;
    if (swap !== 1'b0 || pending !== 1'b1) begin
      miscompares++;
      $display("FAIL queue_holdoff_end: swap=%b pending=%b, required 0/1", swap, pending);
    end
    ticks(2);
    pulse_frame();
    vectors++;
    if (swap !== 1'b1 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL queue_second_swap: swap=%b pending=%b, required 1/0", swap, pending);
    end
    ticks(2);
    for (int f = 0; f < 6; f++) begin
      pulse_frame();
      ticks(2);
    end
    vectors++;
    if (swap_cnt - base !== 2) begin
      miscompares++;
      $display("FAIL queue_total: swaps=%0d, required 2", swap_cnt - base);
    end
  endtask

  task automatic test_reset_armed();
    int base;
    press();
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++;
      $display("FAIL armed_before_reset: pending=%b, required 1", pending);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (pending !== 1'b0 || swap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_discard: pending=%b swap=%b, required 0/0", pending, swap);
    end
    base = swap_cnt;
    for (int f = 0; f < 4; f++) begin
      pulse_frame();
      ticks(2);
    end
    vectors++;
    if (swap_cnt - base !== 0) begin
      miscompares++;
      $display("FAIL reset_no_swap: swaps=%0d, required 0", swap_cnt - base);
    end
  endtask

  task automatic test_auto();
    int base;
    logic exp_swap;
    do_reset();
    auto_en = 1'b1;
    tick();
    for (int f = 1; f <= 10; f++) begin
`ifdef SWAP_AUTO_CYCLE_EN
      exp_swap = (f == 4 || f == 10);
`else
      exp_swap = 1'b0;
`endif
      pulse_frame();
      vectors++;
      if (swap !== exp_swap) begin
        miscompares++;
        $display("FAIL auto_frame_%0d: swap=%b, required %b", f, swap, exp_swap);
      end
      ticks(2);
    end
    auto_en = 1'b0;
    base = swap_cnt;
    for (int f = 0; f < 10; f++) begin
      pulse_frame();
      ticks(2);
    end
    vectors++;
    if (swap_cnt - base !== 0 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL auto_disabled: swaps=%0d pending=%b, required 0/0", swap_cnt - base, pending);
    end
  endtask

  initial begin
    test_reset();
    test_press_swap();
    test_frame_same_cycle();
    test_queue();
    test_reset_armed();
    test_auto();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
